// File: rtl/core_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  // Wide enough to hold MEM_LAT_MAX-1.
  localparam int CNT_W       = 2;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Data-first selector between fetch and data requesters; last_dm hands the
// next contested grant to fetch so it cannot be starved.
module arb_pick
  import core_pkg::*;
(
  input  logic    if_elig,
  input  logic    dm_elig,
  input  logic    last_dm,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    gnt_valid = if_elig | dm_elig;
    gnt_id    = REQ_DM;
    if (if_elig && (!dm_elig || last_dm)) begin
      gnt_id = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and data access,
// one transaction at a time: issue, optional read wait, one-cycle response.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LATENCY < MEM_LAT_MIN || MEM_LATENCY > MEM_LAT_MAX) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be 1..4");
  end

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              last_dm;
  req_id_t           cur_id;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic    if_elig;
  logic    dm_elig;
  logic    gnt_valid;
  req_id_t gnt_id;
  logic    issue;

  // A requester whose valid pulse is up this cycle is still holding the
  // request it just finished; masking it stops a duplicate issue.
  assign if_elig = if_req & ~if_valid;
  assign dm_elig = dm_req & ~dm_valid;

  arb_pick u_pick (
    .if_elig   (if_elig),
    .dm_elig   (dm_elig),
    .last_dm   (last_dm),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // RESP grants exactly like IDLE, so back-to-back accesses have no bubble.
  // Gating with rst_n keeps the combinational strobe quiet during reset.
  assign issue = rst_n && (state != RD_WAIT) && gnt_valid;

  always_comb begin
    mem_en    = issue;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (issue) begin
      if (gnt_id == REQ_DM) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else begin
        mem_addr  = if_addr;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dm  <= 1'b0;
      cur_id   <= REQ_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        RD_WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            if (cur_id == REQ_DM) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (issue) begin
            last_dm <= (gnt_id == REQ_DM);
            cur_id  <= gnt_id;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            // A store needs no read data, so it completes on the next cycle.
            if (gnt_id == REQ_DM && dm_we) begin
              state    <= RESP;
              dm_valid <= 1'b1;
            end else begin
              state <= RD_WAIT;
              cnt   <= CNT_W'(MEM_LATENCY - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  a_valid_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(if_valid && dm_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency 2 main instance plus latency
// 1 and 4 instances sharing the same stimulus.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_valid, dm_valid, mem_en, mem_we;

  logic [DW-1:0] l1_if_rdata, l1_dm_rdata, l1_mem_wdata;
  logic [AW-1:0] l1_mem_addr;
  logic          l1_if_valid, l1_dm_valid, l1_mem_en, l1_mem_we;

  logic [DW-1:0] l4_if_rdata, l4_dm_rdata, l4_mem_wdata;
  logic [AW-1:0] l4_mem_addr;
  logic          l4_if_valid, l4_dm_valid, l4_mem_en, l4_mem_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(l1_if_rdata), .if_valid(l1_if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(l1_dm_rdata), .dm_valid(l1_dm_valid),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(l4_if_rdata), .if_valid(l4_if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(l4_dm_rdata), .dm_valid(l4_dm_valid),
    .mem_en(l4_mem_en), .mem_we(l4_mem_we), .mem_addr(l4_mem_addr), .mem_wdata(l4_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic to_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic to_mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    to_edge();
    rst_n = 1'b0;
    idle_inputs();
    to_edge();
    to_edge();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    to_edge();
    to_mid();
    check("rst_if_valid", if_valid, 0);
    check("rst_dm_valid", dm_valid, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    to_edge();
    rst_n = 1'b1;

    // 1: single fetch, valid three cycles after issue
    to_edge();
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    to_mid();
    check("t1_issue_en", mem_en, 1);
    check("t1_issue_addr", mem_addr, 32'h100);
    check("t1_issue_we", mem_we, 0);
    for (int k = 1; k <= 2; k++) begin
      to_edge();
      to_mid();
      check($sformatf("t1_wait_valid_%0d", k), if_valid, 0);
      check($sformatf("t1_wait_en_%0d", k), mem_en, 0);
    end
    to_edge();
    if_req = 1'b0;
    to_mid();
    check("t1_if_valid", if_valid, 1);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_no_dm_valid", dm_valid, 0);
    to_edge();
    to_mid();
    check("t1_pulse_end", if_valid, 0);
    check("t1_rdata_hold", if_rdata, 32'hDEADBEEF);

    // 2: store wins over pending fetch, fetch issues in the RESP cycle
    to_edge();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
    if_req = 1'b1; if_addr = 32'h200; mem_rdata = 32'hA5A50200;
    to_mid();
    check("t2_st_en", mem_en, 1);
    check("t2_st_we", mem_we, 1);
    check("t2_st_addr", mem_addr, 32'h40);
    check("t2_st_wdata", mem_wdata, 32'h12345678);
    to_edge();
    dm_req = 1'b0; dm_we = 1'b0;
    to_mid();
    check("t2_dm_valid", dm_valid, 1);
    check("t2_if_issue_en", mem_en, 1);
    check("t2_if_issue_we", mem_we, 0);
    check("t2_if_issue_addr", mem_addr, 32'h200);
    to_edge();
    to_mid();
    check("t2_dm_pulse_end", dm_valid, 0);
    to_edge();
    to_mid();
    check("t2_if_not_yet", if_valid, 0);
    to_edge();
    if_req = 1'b0;
    to_mid();
    check("t2_if_valid", if_valid, 1);
    check("t2_if_rdata", if_rdata, 32'hA5A50200);

    // 3: contested load goes to DM, then IF despite a fresh dm_req
    to_edge();
    if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; mem_rdata = 32'h11112222;
    to_mid();
    check("t3_dm_issue_en", mem_en, 1);
    check("t3_dm_issue_addr", mem_addr, 32'h80);
    check("t3_dm_issue_we", mem_we, 0);
    to_edge();
    to_edge();
    to_edge();
    dm_addr = 32'h84; mem_rdata = 32'h33334444;
    to_mid();
    check("t3_dm_valid", dm_valid, 1);
    check("t3_dm_rdata", dm_rdata, 32'h11112222);
    check("t3_if_issue_en", mem_en, 1);
    check("t3_if_issue_addr", mem_addr, 32'h300);
    to_edge();
    to_edge();
    to_edge();
    if_req = 1'b0;
    to_mid();
    check("t3_if_valid", if_valid, 1);
    check("t3_if_rdata", if_rdata, 32'h33334444);
    check("t3_dm2_issue_en", mem_en, 1);
    check("t3_dm2_issue_addr", mem_addr, 32'h84);
    to_edge();
    to_edge();
    to_edge();
    dm_req = 1'b0;
    to_mid();
    check("t3_dm2_valid", dm_valid, 1);
    check("t3_dm2_rdata", dm_rdata, 32'h33334444);

    // 4: continuous contention alternates DM, IF, DM, ...
    do_reset();
    for (int k = 0; k < 21; k++) begin
      to_edge();
      if (k == 0) begin
        if_req = 1'b1; if_addr = 32'h500;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600; mem_rdata = 32'h0BADF00D;
      end
      to_mid();
      check($sformatf("t4_en_%0d", k), mem_en, 32'((k % 3) == 0));
      if ((k % 3) == 0) begin
        check($sformatf("t4_addr_%0d", k), mem_addr, ((k / 3) % 2 == 0) ? 32'h600 : 32'h500);
      end
      check($sformatf("t4_if_valid_%0d", k), if_valid,
            32'((k % 3) == 0 && k > 0 && ((k / 3 - 1) % 2) == 1));
      check($sformatf("t4_dm_valid_%0d", k), dm_valid,
            32'((k % 3) == 0 && k > 0 && ((k / 3 - 1) % 2) == 0));
    end
    to_edge();
    idle_inputs();
    for (int k = 0; k < 4; k++) to_edge();

    // 5: reset in the middle of a load
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h700; mem_rdata = 32'h55555555;
    to_mid();
    check("t5_issue_en", mem_en, 1);
    to_edge();
    rst_n = 1'b0;
    dm_req = 1'b0;
    to_mid();
    check("t5_rst_mem_en", mem_en, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_mem_wdata", mem_wdata, 0);
    check("t5_rst_mem_we", mem_we, 0);
    check("t5_rst_if_rdata", if_rdata, 0);
    check("t5_rst_dm_rdata", dm_rdata, 0);
    check("t5_rst_dm_valid", dm_valid, 0);
    to_edge();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      to_edge();
      to_mid();
      check($sformatf("t5_no_valid_%0d", k), dm_valid, 0);
    end
    to_edge();
    dm_req = 1'b1; dm_addr = 32'h700; mem_rdata = 32'h77777777;
    to_mid();
    check("t5_reissue_en", mem_en, 1);
    check("t5_reissue_addr", mem_addr, 32'h700);
    to_edge();
    to_edge();
    to_edge();
    dm_req = 1'b0;
    to_mid();
    check("t5_reissue_valid", dm_valid, 1);
    check("t5_reissue_rdata", dm_rdata, 32'h77777777);

    // 6: latency sweep, fetch valid at issue+2 (L=1) and issue+5 (L=4)
    do_reset();
    to_edge();
    if_req = 1'b1; if_addr = 32'h900; mem_rdata = 32'h99990000;
    to_mid();
    check("t6_l1_issue", l1_mem_en, 1);
    check("t6_l4_issue", l4_mem_en, 1);
    to_edge();
    to_mid();
    check("t6_l1_early", l1_if_valid, 0);
    to_edge();
    to_mid();
    check("t6_l1_valid", l1_if_valid, 1);
    check("t6_l1_rdata", l1_if_rdata, 32'h99990000);
    check("t6_l4_early2", l4_if_valid, 0);
    to_edge();
    to_mid();
    check("t6_main_valid", if_valid, 1);
    to_edge();
    to_mid();
    check("t6_l4_early4", l4_if_valid, 0);
    to_edge();
    if_req = 1'b0;
    to_mid();
    check("t6_l4_valid", l4_if_valid, 1);
    check("t6_l4_rdata", l4_if_rdata, 32'h99990000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between instruction fetch (IF) and data access (DM).
- DM traffic is LDM (load) and STM (store).
- Sits between the core's fetch stage, the memory stage and the unified memory macro.
- Sequences each access through issue, wait and response phases. Returns stall-relevant valid pulses to each requester.
- Applies data-first priority with an anti-starvation rule for fetch.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MEM_LATENCY, 2, cycles from the issue edge until mem_rdata is valid. Legal range 1..4.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high with stable if_addr until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; meaningful only while if_valid is high.
- if_valid  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held high with stable dm_we/dm_addr/dm_wdata until dm_valid.
- dm_we  in  1  1 = STM, 0 = LDM.
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; meaningful only while dm_valid is high.
- dm_valid  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state IDLE, wait counter 0, last_dm 0, if_valid 0, dm_valid 0. if_rdata and dm_rdata are 0. mem_en, mem_we, mem_addr and mem_wdata are 0.
- FSM states: IDLE, RD_WAIT, RESP.
- Eligible requests in IDLE: a requester whose valid pulse is asserted in the current cycle is not eligible that cycle. This consumes the still-high req.
- Grant rule in IDLE:
  - Only one eligible requester: grant it.
  - Both eligible: grant IF if last_dm=1, otherwise grant DM.
- Issue cycle (IDLE with a grant):
  - mem_en=1 and mem_addr = granted address, driven combinationally in the same cycle.
  - mem_we = dm_we and mem_wdata = dm_wdata for a DM grant. mem_we=0 for an IF grant.
  - last_dm updates on the edge: 1 for a DM grant, 0 for an IF grant.
- Store path: IDLE -> RESP. dm_valid pulses the cycle after issue. The FSM is back in IDLE and may issue again in that same cycle.
- Load or fetch path: IDLE -> RD_WAIT.
  - Counter loads MEM_LATENCY-1 and decrements each cycle.
  - When the counter reaches 0, mem_rdata is captured on that edge.
  - The matching valid pulses with the registered data in the next cycle (RESP).
  - Total latency: valid at issue+MEM_LATENCY+1.
- RESP is a one-cycle state that asserts the matching valid and behaves as IDLE for granting. Back-to-back accesses therefore cost no extra bubble.
- Idle outputs: outside the issue cycle, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last value; they are don't-care.
- rdata outputs hold their last captured value between pulses.
- A requester dropping req mid-transaction does not abort the access. The valid pulse still occurs and the requester ignores it.
- Exactly one transaction is outstanding at any time; no pipelining of issues.
- If if_valid and dm_valid would ever coincide, that is an assertion failure. By construction they never do.
- Reset mid-transaction: all state returns to reset values immediately; no valid pulse follows.
- Requesters must re-present their request after reset.

Decomposition:
- Shared package core_pkg holds:
  - the arb_state_t enum (IDLE, RD_WAIT, RESP);
  - the requester id enum (REQ_IF, REQ_DM);
  - the MEM_LATENCY legal-range constants.
- One natural sub-module: arb_pick. It is the combinational priority/anti-starvation selector, taking eligible bits and last_dm and returning a grant id.
- The FSM, counter and response registers stay in the top module.

Test Plan:
1. Reset, then if_req=1 with if_addr=0x100 and mem_rdata=0xDEADBEEF at the read edge (MEM_LATENCY=2):
   - mem_en=1 and mem_addr=0x100 at cycle T;
   - if_valid=1 with if_rdata=0xDEADBEEF at T+3, for exactly one cycle.
2. dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0x12345678:
   - mem_en=1, mem_we=1, mem_wdata=0x12345678 at T;
   - dm_valid at T+1;
   - a pending if_req is issued at T+1 (mem_en=1, mem_we=0).
3. if_req and dm_req (LDM) both raised at T with last_dm=0:
   - DM is issued at T and dm_valid at T+3;
   - IF is issued at T+3, even though a new dm_req is present, because last_dm=1.
4. Continuous if_req and dm_req for 20 cycles:
   - grants alternate DM, IF, DM, IF;
   - no requester waits more than two transactions.
5. rst_n asserted low at T+1 of a load:
   - all outputs are 0 immediately;
   - no dm_valid is seen after release;
   - a re-presented request completes normally.
6. Sweep MEM_LATENCY=1 and 4 with a single fetch: if_valid arrives at issue+2 and issue+5 respectively.
